ysyx_22050710_sram_arbiter: RTL and testbench

- Parametrised N-channel arbiter for the SRAM-like req/addr_ok/data_ok protocol.
- Merges the core's inst and data SRAM channels, plus future masters (e.g. DMA, debug), onto one downstream SRAM-like port.
- Tracks outstanding requests in an in-order ID FIFO so each data_ok/rdata is routed back to the channel that issued it.
- Sits between the core top and the memory bridge.

---
 rtl/ysyx_22050710_sram_arbiter.sv | 156 +++++++++++++++
 tb/tb_ysyx_22050710_sram_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_sram_arbiter.sv
// N-channel arbiter for the SRAM-like req/addr_ok/data_ok protocol with an in-order outstanding-ID FIFO.
// Define YSYX_22050710_SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module ysyx_22050710_sram_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int SRAM_ADDR_WD    = 32,
  parameter int SRAM_DATA_WD    = 64,
  parameter int SRAM_WMASK_WD   = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_CH-1:0]                 i_ch_req,
  input  logic [NUM_CH-1:0]                 i_ch_wr,
  input  logic [2*NUM_CH-1:0]               i_ch_size,
  input  logic [NUM_CH*SRAM_ADDR_WD-1:0]    i_ch_addr,
  input  logic [NUM_CH*SRAM_WMASK_WD-1:0]   i_ch_wstrb,
  input  logic [NUM_CH*SRAM_DATA_WD-1:0]    i_ch_wdata,
  output logic [NUM_CH-1:0]                 o_ch_addr_ok,
  output logic [NUM_CH-1:0]                 o_ch_data_ok,
  output logic [SRAM_DATA_WD-1:0]           o_ch_rdata,
  output logic                              o_mem_req,
  output logic                              o_mem_wr,
  output logic [1:0]                        o_mem_size,
  output logic [SRAM_ADDR_WD-1:0]           o_mem_addr,
  output logic [SRAM_WMASK_WD-1:0]          o_mem_wstrb,
  output logic [SRAM_DATA_WD-1:0]           o_mem_wdata,
  input  logic                              i_mem_addr_ok,
  input  logic                              i_mem_data_ok,
  input  logic [SRAM_DATA_WD-1:0]           i_mem_rdata
);
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic              lock_vld;
  logic [ID_W-1:0]   lock_id;
  logic [ID_W-1:0]   fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              sel_vld;
  logic [ID_W-1:0]   sel_id;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [NUM_CH-1:0] grant;
  logic              push;
  logic              pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cand;
  int              rr_idx;

  // Search starts at rr_ptr and wraps; first requester found wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    rr_idx  = 0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
      cand = ID_W'(rr_idx);
      if (!sel_vld && i_ch_req[cand]) begin
        sel_vld = 1'b1;
        sel_id  = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (int'(gnt_id) == NUM_CH - 1) ? '0 : gnt_id + 1'b1;
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_vld && i_ch_req[i]) begin
        sel_vld = 1'b1;
        sel_id  = ID_W'(i);
      end
    end
  end
`endif

  // A locked request already reserved its FIFO slot, so only fresh selections look at full.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = sel_id;
    if (!i_rst) begin
      if (lock_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = lock_id;
      end else if (!full && sel_vld) begin
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_id] = 1'b1;
  end

  assign o_mem_req    = gnt_vld;
  assign o_mem_wr     = i_ch_wr[gnt_id];
  assign o_mem_size   = i_ch_size[2*int'(gnt_id) +: 2];
  assign o_mem_addr   = i_ch_addr[int'(gnt_id)*SRAM_ADDR_WD +: SRAM_ADDR_WD];
  assign o_mem_wstrb  = i_ch_wstrb[int'(gnt_id)*SRAM_WMASK_WD +: SRAM_WMASK_WD];
  assign o_mem_wdata  = i_ch_wdata[int'(gnt_id)*SRAM_DATA_WD +: SRAM_DATA_WD];
  assign o_ch_addr_ok = grant & {NUM_CH{i_mem_addr_ok}};

  assign push = gnt_vld & i_mem_addr_ok;
  assign pop  = i_mem_data_ok & ~empty & ~i_rst;

  always_comb begin
    o_ch_data_ok = '0;
    if (pop) o_ch_data_ok[fifo[rd_ptr]] = 1'b1;
  end
  assign o_ch_rdata = i_mem_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      lock_vld <= gnt_vld & ~i_mem_addr_ok;
      if (gnt_vld) lock_id <= gnt_id;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo[wr_ptr] <= gnt_id;
  end
endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Self-checking bench for ysyx_22050710_sram_arbiter: directed scenarios plus randomized traffic
// against a queue-based model of grants and in-order response routing.
module tb_ysyx_22050710_sram_arbiter;
  localparam int NCH  = 2;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MW   = 8;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_wr;
  logic [2*NCH-1:0]  ch_size;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*MW-1:0] ch_wstrb;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_addr_ok;
  logic [NCH-1:0]    ch_data_ok;
  logic [DW-1:0]     ch_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_wstrb;
  logic [DW-1:0]     mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DW-1:0]     mem_rdata;

  // per-channel payloads, packed onto the DUT buses below
  logic [AW-1:0] pa [NCH];
  logic          pw [NCH];
  logic [1:0]    ps [NCH];
  logic [MW-1:0] pm [NCH];
  logic [DW-1:0] pd [NCH];

  // reference model: outstanding channel IDs in issue order, plus a stalled request
  logic [0:0] exp_q[$];
  logic       m_lock;
  logic [0:0] m_lock_ch;
  logic [0:0] m_rr;
  int         checks;
  int         errors;

  ysyx_22050710_sram_arbiter #(
    .NUM_CH(NCH), .SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW),
    .SRAM_WMASK_WD(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch_req(ch_req), .i_ch_wr(ch_wr), .i_ch_size(ch_size),
    .i_ch_addr(ch_addr), .i_ch_wstrb(ch_wstrb), .i_ch_wdata(ch_wdata),
    .o_ch_addr_ok(ch_addr_ok), .o_ch_data_ok(ch_data_ok), .o_ch_rdata(ch_rdata),
    .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_size(mem_size),
    .o_mem_addr(mem_addr), .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_addr_ok(mem_addr_ok), .i_mem_data_ok(mem_data_ok), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_wr    = '0;
    ch_size  = '0;
    ch_addr  = '0;
    ch_wstrb = '0;
    ch_wdata = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_wr[k]             = pw[k];
      ch_size[2*k +: 2]    = ps[k];
      ch_addr[k*AW +: AW]  = pa[k];
      ch_wstrb[k*MW +: MW] = pm[k];
      ch_wdata[k*DW +: DW] = pd[k];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time %0t limit 500000", $time);
    $fatal(1);
  end

  // Expected one-hot grant for the current inputs, from the arbitration rules.
  function automatic logic [1:0] exp_grant();
    if (rst) return 2'b00;
    if (m_lock) return m_lock_ch ? 2'b10 : 2'b01;
    if (exp_q.size() >= MAXO) return 2'b00;
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
    if (ch_req[m_rr])  return m_rr ? 2'b10 : 2'b01;
    if (ch_req[~m_rr]) return m_rr ? 2'b01 : 2'b10;
`else
    if (ch_req[0]) return 2'b01;
    if (ch_req[1]) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_data_ok();
    if (rst || !mem_data_ok || exp_q.size() == 0) return 2'b00;
    return exp_q[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic new_payload(input int k);
    pa[k] = $urandom;
    pw[k] = 1'($urandom_range(0, 1));
    ps[k] = 2'($urandom_range(0, 3));
    pm[k] = 8'($urandom_range(0, 255));
    pd[k] = {$urandom, $urandom};
  endtask

  task automatic set_inputs(input logic [1:0] req, input logic aok, input logic dok);
    ch_req      = req;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    #1;
  endtask

  // Update the model with this cycle's handshakes, then move to just after the next edge.
  task automatic advance();
    logic [1:0] g;
    g = exp_grant();
    if (rst) begin
      exp_q.delete();
      m_lock = 1'b0;
      m_rr   = 1'b0;
    end else begin
      if (mem_data_ok && exp_q.size() > 0) void'(exp_q.pop_front());
      if (g != 2'b00) begin
        if (mem_addr_ok) begin
          exp_q.push_back(g[1]);
          m_lock = 1'b0;
          m_rr   = ~g[1];
        end else begin
          m_lock    = 1'b1;
          m_lock_ch = g[1];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2*MAXO && exp_q.size() > 0; i++) begin
      set_inputs(2'b00, 1'b0, 1'b1);
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(2'($urandom_range(1, 3)), 1'b1, 1'b1);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (ch_addr_ok !== 2'b00) begin errors++; $display("FAIL reset_addr_ok got %b exp 00", ch_addr_ok); end
      checks++; if (ch_data_ok !== 2'b00) begin errors++; $display("FAIL reset_data_ok got %b exp 00", ch_data_ok); end
      advance();
    end
    rst = 1'b0;
    set_inputs(2'b00, 1'b1, 1'b1);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_reset_mem_req got %b exp 0", mem_req); end
    checks++; if (ch_data_ok !== 2'b00) begin errors++; $display("FAIL post_reset_data_ok got %b exp 00", ch_data_ok); end
    advance();
  endtask

  task automatic test_single_read();
    pa[1] = 32'h8000_0010;
    pw[1] = 1'b0;
    set_inputs(2'b10, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== 2'b10) begin errors++; $display("FAIL single_addr_ok got %b exp 10", ch_addr_ok); end
    checks++; if (mem_addr !== 32'h8000_0010 || mem_wr !== 1'b0)
      begin errors++; $display("FAIL single_payload got %h/%b exp 80000010/0", mem_addr, mem_wr); end
    advance();
    set_inputs(2'b00, 1'b0, 1'b0);
    checks++; if (ch_data_ok !== 2'b00) begin errors++; $display("FAIL single_early_data_ok got %b exp 00", ch_data_ok); end
    advance();
    mem_rdata = 64'h1122_3344_5566_7788;
    set_inputs(2'b00, 1'b0, 1'b1);
    checks++; if (ch_data_ok !== 2'b10) begin errors++; $display("FAIL single_data_ok got %b exp 10", ch_data_ok); end
    checks++; if (ch_rdata !== 64'h1122_3344_5566_7788)
      begin errors++; $display("FAIL single_rdata got %h exp 1122334455667788", ch_rdata); end
    advance();
  endtask

  task automatic test_contention();
    logic [1:0] exp2;
    logic [1:0] rest;
    new_payload(0);
    new_payload(1);
    for (int i = 0; i < 3; i++) begin
      set_inputs(2'b11, 1'b0, 1'b0);
      checks++; if (mem_req !== 1'b1 || mem_addr !== pa[0])
        begin errors++; $display("FAIL hold_ch0 cyc %0d got req %b addr %h exp 1 %h", i, mem_req, mem_addr, pa[0]); end
      checks++; if (ch_addr_ok !== 2'b00) begin errors++; $display("FAIL hold_addr_ok got %b exp 00", ch_addr_ok); end
      advance();
    end
    set_inputs(2'b11, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== 2'b01) begin errors++; $display("FAIL contend_first got %b exp 01", ch_addr_ok); end
    advance();
    set_inputs(2'b10, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== 2'b10 || mem_addr !== pa[1])
      begin errors++; $display("FAIL contend_second got %b %h exp 10 %h", ch_addr_ok, mem_addr, pa[1]); end
    advance();
    drain();
    // second round: ch0 re-requests right after its own handshake while ch1 waits
    new_payload(0);
    new_payload(1);
    set_inputs(2'b11, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== 2'b01) begin errors++; $display("FAIL round2_first got %b exp 01", ch_addr_ok); end
    advance();
    new_payload(0);
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
    exp2 = 2'b10;
`else
    exp2 = 2'b01;
`endif
    set_inputs(2'b11, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== exp2) begin errors++; $display("FAIL round2_second got %b exp %b", ch_addr_ok, exp2); end
    advance();
    rest = ~exp2;
    set_inputs(rest, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== rest) begin errors++; $display("FAIL round2_third got %b exp %b", ch_addr_ok, rest); end
    advance();
    set_inputs(2'b00, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < MAXO; i++) begin
      new_payload(0);
      set_inputs(2'b01, 1'b1, 1'b0);
      checks++; if (ch_addr_ok !== 2'b01) begin errors++; $display("FAIL fill_%0d got %b exp 01", i, ch_addr_ok); end
      advance();
    end
    new_payload(0);
    set_inputs(2'b01, 1'b1, 1'b0);
    checks++; if (mem_req !== 1'b0 || ch_addr_ok !== 2'b00)
      begin errors++; $display("FAIL full_block got %b/%b exp 0/00", mem_req, ch_addr_ok); end
    advance();
    set_inputs(2'b01, 1'b1, 1'b1);
    checks++; if (ch_data_ok !== 2'b01) begin errors++; $display("FAIL full_pop got %b exp 01", ch_data_ok); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_pop_req got %b exp 0", mem_req); end
    advance();
    set_inputs(2'b01, 1'b1, 1'b0);
    checks++; if (mem_req !== 1'b1 || ch_addr_ok !== 2'b01 || mem_addr !== pa[0])
      begin errors++; $display("FAIL full_resume got %b/%b/%h exp 1/01/%h", mem_req, ch_addr_ok, mem_addr, pa[0]); end
    advance();
    set_inputs(2'b00, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_interleave();
    logic [1:0] rq   [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic       dk   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] eaok [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] edok [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 8; i++) begin
      if (rq[i] != 2'b00) new_payload(rq[i][1] ? 1 : 0);
      set_inputs(rq[i], 1'b1, dk[i]);
      checks++; if (ch_addr_ok !== eaok[i])
        begin errors++; $display("FAIL inter_addr_ok cyc %0d got %b exp %b", i, ch_addr_ok, eaok[i]); end
      checks++; if (ch_data_ok !== edok[i])
        begin errors++; $display("FAIL inter_data_ok cyc %0d got %b exp %b", i, ch_data_ok, edok[i]); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    new_payload(0);
    new_payload(1);
    set_inputs(2'b01, 1'b1, 1'b0);
    advance();
    set_inputs(2'b10, 1'b1, 1'b0);
    advance();
    rst = 1'b1;
    set_inputs(2'b11, 1'b0, 1'b1);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", mem_req); end
    checks++; if (ch_data_ok !== 2'b00) begin errors++; $display("FAIL midrst_data_ok got %b exp 00", ch_data_ok); end
    advance();
    rst = 1'b0;
    set_inputs(2'b00, 1'b0, 1'b1);
    checks++; if (ch_data_ok !== 2'b00) begin errors++; $display("FAIL after_rst_data_ok got %b exp 00", ch_data_ok); end
    advance();
    new_payload(1);
    set_inputs(2'b10, 1'b1, 1'b0);
    checks++; if (ch_addr_ok !== 2'b10 || mem_addr !== pa[1])
      begin errors++; $display("FAIL after_rst_grant got %b/%h exp 10/%h", ch_addr_ok, mem_addr, pa[1]); end
    advance();
    set_inputs(2'b00, 1'b0, 1'b1);
    checks++; if (ch_data_ok !== 2'b10) begin errors++; $display("FAIL after_rst_resp got %b exp 10", ch_data_ok); end
    advance();
  endtask

  task automatic test_random();
    logic [1:0] act;
    logic [1:0] eg;
    logic [1:0] ed;
    int         gid;
    act = 2'b00;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!act[k] && $urandom_range(0, 2) == 0) begin
          act[k] = 1'b1;
          new_payload(k);
        end
      end
      mem_rdata = {$urandom, $urandom};
      set_inputs(act, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      eg = exp_grant();
      ed = exp_data_ok();
      checks++; if (mem_req !== (eg != 2'b00))
        begin errors++; $display("FAIL rand_req cyc %0d got %b exp %b", i, mem_req, eg != 2'b00); end
      checks++; if (ch_addr_ok !== (eg & {2{mem_addr_ok}}))
        begin errors++; $display("FAIL rand_addr_ok cyc %0d got %b exp %b", i, ch_addr_ok, eg & {2{mem_addr_ok}}); end
      checks++; if (ch_data_ok !== ed)
        begin errors++; $display("FAIL rand_data_ok cyc %0d got %b exp %b", i, ch_data_ok, ed); end
      if (eg != 2'b00) begin
        gid = eg[1] ? 1 : 0;
        checks++; if ({mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata} !== {pa[gid], pw[gid], ps[gid], pm[gid], pd[gid]})
          begin errors++; $display("FAIL rand_payload cyc %0d got %h exp %h", i, mem_addr, pa[gid]); end
        if (mem_addr_ok) act[gid] = 1'b0;
      end
      if (ed != 2'b00) begin
        checks++; if (ch_rdata !== mem_rdata)
          begin errors++; $display("FAIL rand_rdata cyc %0d got %h exp %h", i, ch_rdata, mem_rdata); end
      end
      advance();
    end
    set_inputs(2'b00, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_lock    = 1'b0;
    m_lock_ch = 1'b0;
    m_rr      = 1'b0;
    rst       = 1'b1;
    mem_rdata = '0;
    for (int k = 0; k < NCH; k++) new_payload(k);
    set_inputs(2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_full();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
